// File: rtl/func_result_collector.sv
// func_result_collector
// Watches the proc_state of a generated C-function FSM, samples its result on
// every completed invocation, grades it against EXPECT and queues
// {match,result} in a small FIFO with a valid/ready readback port.
// Saturating pass/fail counters and a sticky overflow flag summarise the run.
module func_result_collector #(
   parameter int              DW         = 8,
   parameter int              SW         = 3,
   parameter int              LAST_STATE = 6,
   parameter logic [DW-1:0]   EXPECT     = 8'h09,
   parameter int              DEPTH      = 4,
   parameter int              CW         = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [SW-1:0] fn_state,
   input  logic [DW-1:0] fn_out,
   input  logic          clr,
   input  logic          stop_fail,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_match,
   output logic [CW-1:0] pass_cnt,
   output logic [CW-1:0] fail_cnt,
   output logic          ovf,
   output logic          halted
);

   localparam int PW = $clog2(DEPTH);
   localparam int EW = DW + 1;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          halted_q, halted_d;
   logic [SW-1:0] prev_state_q, prev_state_d;
   logic [PW:0]   wr_ptr_q, wr_ptr_d;
   logic [PW:0]   rd_ptr_q, rd_ptr_d;
   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] mem_d [DEPTH];
   logic [CW-1:0] pass_q, pass_d;
   logic [CW-1:0] fail_q, fail_d;
   logic          ovf_q, ovf_d;

   logic          done;
   logic          fifo_empty;
   logic          fifo_full;
   logic          pop;
   logic          sample;
   logic          is_match;
   logic          push_ok;
   logic [EW-1:0] head;

   // Event detection, FIFO status and handshake qualifiers. An invocation has
   // completed when the upstream FSM leaves LAST_STATE; fn_out is final then.
   always_comb begin
      done       = (prev_state_q == SW'(LAST_STATE)) && (fn_state != SW'(LAST_STATE));
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
      pop        = !fifo_empty && m_ready;
      sample     = (state_q == ST_RUN) && done && !clr;
      is_match   = (fn_out == EXPECT);
      push_ok    = sample && (!fifo_full || pop);
      head       = mem_q[rd_ptr_q[PW-1:0]];
   end

   // Next-state logic for the FSM, FIFO, counters and sticky flags. clr wins
   // over everything, including an event arriving in the same cycle.
   always_comb begin
      state_d      = state_q;
      halted_d     = halted_q;
      prev_state_d = fn_state;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      mem_d        = mem_q;
      pass_d       = pass_q;
      fail_d       = fail_q;
      ovf_d        = ovf_q;

      if (clr) begin
         state_d  = ST_SYNC;
         halted_d = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         pass_d   = '0;
         fail_d   = '0;
         ovf_d    = 1'b0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
         end

         if (push_ok) begin
            mem_d[wr_ptr_q[PW-1:0]] = {is_match, fn_out};
            wr_ptr_d                = wr_ptr_q + (PW+1)'(1);
         end

         if (sample && !push_ok) begin
            ovf_d = 1'b1;
         end

         if (sample) begin
            if (is_match) begin
               if (pass_q != {CW{1'b1}}) begin
                  pass_d = pass_q + CW'(1);
               end
            end else begin
               if (fail_q != {CW{1'b1}}) begin
                  fail_d = fail_q + CW'(1);
               end
            end
         end

         case (state_q)
            ST_SYNC: begin
               if (fn_state == '0) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (sample && !is_match && stop_fail) begin
                  state_d  = ST_HALT;
                  halted_d = 1'b1;
               end
            end
            ST_HALT: begin
               state_d  = ST_HALT;
               halted_d = 1'b1;
            end
            default: begin
               state_d  = ST_SYNC;
               halted_d = 1'b0;
            end
         endcase
      end
   end

   // State registers; reset parks the FSM in SYNC so a run already in
   // progress when reset releases is never sampled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_SYNC;
         halted_q     <= 1'b0;
         prev_state_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         pass_q       <= '0;
         fail_q       <= '0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         halted_q     <= halted_d;
         prev_state_q <= prev_state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         mem_q        <= mem_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         ovf_q        <= ovf_d;
      end
   end

   // Output port; the head entry is masked to zero while the FIFO is empty.
   always_comb begin
      m_valid  = !fifo_empty;
      m_data   = fifo_empty ? '0 : head[DW-1:0];
      m_match  = !fifo_empty && head[DW];
      pass_cnt = pass_q;
      fail_cnt = fail_q;
      ovf      = ovf_q;
      halted   = halted_q;
   end

endmodule
